// File: rtl/input_stream_mux2_1_pkg.sv
// Shared types and default sizing for the two-lane operand streamer.
package input_stream_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_ARMED  = 2'd1,
      ST_STREAM = 2'd2
   } lane_state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/input_stream_mux2_1_if.sv
// Block-in / word-out bus of the two-lane operand streamer.
interface input_stream_mux2_1_if #(
   parameter int WIDTH = input_stream_pkg::DEF_WIDTH,
   parameter int DEPTH = input_stream_pkg::DEF_DEPTH
);
   // Handshake: a block moves on a rising edge where in_valid && in_ready; in_ready
   // never depends on in_valid, and out_validN alone qualifies out_dataN.
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH*DEPTH-1:0]   in_data0;
   logic [WIDTH*DEPTH-1:0]   in_data1;
   logic [WIDTH-1:0]         out_data0;
   logic [WIDTH-1:0]         out_data1;
   logic                     out_valid0;
   logic                     out_valid1;
   logic [1:0]               lane_done;

   modport master (
      output in_valid, in_data0, in_data1,
      input  in_ready, out_data0, out_data1, out_valid0, out_valid1, lane_done
   );

   modport slave (
      input  in_valid, in_data0, in_data1,
      output in_ready, out_data0, out_data1, out_valid0, out_valid1, lane_done
   );

endinterface

// File: rtl/input_stream_mux2_1_stream_lane.sv
// One operand lane: block buffer, EMPTY/ARMED/STREAM sequencer, output word and done pulse.
// STREAM_ZERO_FILL_EN forces the output word to zero whenever it is not valid.
module stream_lane
   import input_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_en,
   input  logic                   i_hold,
   input  logic                   i_load,
   input  logic [WIDTH*DEPTH-1:0] i_block,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_valid,
   output logic                   o_done,
   output logic                   o_empty,
   output lane_state_t            o_state
);

   localparam int PTRW = $clog2(DEPTH + 1);
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_EMPTY  = ST_EMPTY;
   localparam logic [1:0] S_ARMED  = ST_ARMED;
   localparam logic [1:0] S_STREAM = ST_STREAM;

   logic [1:0]       r_state;
   logic [PTRW-1:0]  r_ptr;
   logic [WIDTH-1:0] r_buf [DEPTH];
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_done;
   logic [WIDTH-1:0] w_word;
   logic [WIDTH-1:0] w_idle_data;

   assign w_word = r_buf[r_ptr[IDXW-1:0]];

`ifdef STREAM_ZERO_FILL_EN
   assign w_idle_data = '0;
`else
   assign w_idle_data = r_data;
`endif

   // The buffer is only rewritten by a load, so a restart after abort replays the same block.
   always_ff @(posedge i_clk) begin
      if (i_load && (r_state == S_EMPTY)) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_buf[k] <= i_block[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_EMPTY;
         r_ptr   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (i_en) begin
            r_done <= 1'b0;
         end
         case (r_state)
            S_EMPTY: begin
               if (i_load) begin
                  r_state <= S_ARMED;
                  r_ptr   <= '0;
               end
            end
            S_ARMED: begin
               if (i_en && !i_hold) begin
                  r_data  <= r_buf[0];
                  r_valid <= 1'b1;
                  r_ptr   <= PTRW'(1);
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               // Abort ignores en so the control stage can always pull a lane back.
               if (i_hold) begin
                  r_valid <= 1'b0;
                  r_data  <= w_idle_data;
                  r_ptr   <= '0;
                  r_state <= S_ARMED;
               end else if (i_en) begin
                  if (r_ptr == PTRW'(DEPTH)) begin
                     r_valid <= 1'b0;
                     r_data  <= w_idle_data;
                     r_done  <= 1'b1;
                     r_ptr   <= '0;
                     r_state <= S_EMPTY;
                  end else begin
                     r_data <= w_word;
                     r_ptr  <= r_ptr + PTRW'(1);
                  end
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_done  = r_done;
   assign o_empty = (r_state == S_EMPTY);
   assign o_state = lane_state_t'(r_state);

endmodule

// File: rtl/input_stream_mux2_1.sv
// Two-lane operand streamer feeding the Multi-MAC array; lanes release independently.
// STREAM_ZERO_FILL_EN (in stream_lane) zeroes lane words outside their valid cycles.
module input_stream_mux2_1
   import input_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   input  logic [1:0]            i_mux_reset,
   input_stream_mux2_1_if.slave  io_bus,
   output lane_state_t           o_dbg_state0,
   output lane_state_t           o_dbg_state1
);

   logic             w_empty0;
   logic             w_empty1;
   logic             w_in_ready;
   logic             w_load;
   logic [WIDTH-1:0] w_data0;
   logic [WIDTH-1:0] w_data1;
   logic             w_valid0;
   logic             w_valid1;
   logic             w_done0;
   logic             w_done1;

   // A block is shared by both lanes, so both must be drained before the next one.
   assign w_in_ready = w_empty0 & w_empty1;
   assign w_load     = io_bus.in_valid & w_in_ready;

   stream_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_hold  (i_mux_reset[0]),
      .i_load  (w_load),
      .i_block (io_bus.in_data0),
      .o_data  (w_data0),
      .o_valid (w_valid0),
      .o_done  (w_done0),
      .o_empty (w_empty0),
      .o_state (o_dbg_state0)
   );

   stream_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_hold  (i_mux_reset[1]),
      .i_load  (w_load),
      .i_block (io_bus.in_data1),
      .o_data  (w_data1),
      .o_valid (w_valid1),
      .o_done  (w_done1),
      .o_empty (w_empty1),
      .o_state (o_dbg_state1)
   );

   assign io_bus.in_ready   = w_in_ready;
   assign io_bus.out_data0  = w_data0;
   assign io_bus.out_data1  = w_data1;
   assign io_bus.out_valid0 = w_valid0;
   assign io_bus.out_valid1 = w_valid1;
   assign io_bus.lane_done  = {w_done1, w_done0};

endmodule

// File: tb/tb_input_stream_mux2_1.sv
// Directed bench for input_stream_mux2_1 with a per-cycle lane model and literal stream checks.
module tb_input_stream_mux2_1;
   import input_stream_pkg::*;

   localparam int W = 16;
   localparam int D = 4;
`ifdef STREAM_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   // clock / reset
   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  mr;
   lane_state_t dbg0;
   lane_state_t dbg1;

   always #5 clk = ~clk;

   input_stream_mux2_1_if #(.WIDTH(W), .DEPTH(D)) bus ();

   input_stream_mux2_1 #(.WIDTH(W), .DEPTH(D)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_en         (en),
      .i_mux_reset  (mr),
      .io_bus       (bus),
      .o_dbg_state0 (dbg0),
      .o_dbg_state1 (dbg1)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model: per lane, whether a block is held and how many of its words have been emitted
   bit         m_has   [2];
   int         m_cnt   [2];
   logic [W-1:0] m_words [2][D];
   logic [W-1:0] m_data  [2];
   bit         m_valid [2];
   bit         m_done  [2];
   bit         chk_on = 1'b0;
   bit         last_en;
   bit         last_rst;
   int         acc = 0;

   always @(posedge clk) begin
      bit ready;
      bit load;
      logic [W*D-1:0] blk;
      ready    = !m_has[0] && !m_has[1];
      load     = bus.in_valid && ready;
      last_en  = en;
      last_rst = rst_n;
      if (rst_n && load) acc++;
      for (int i = 0; i < 2; i++) begin
         blk = (i == 0) ? bus.in_data0 : bus.in_data1;
         if (!rst_n) begin
            m_has[i] = 0; m_cnt[i] = 0; m_data[i] = '0; m_valid[i] = 0; m_done[i] = 0;
         end else if (m_has[i] && m_cnt[i] > 0 && mr[i]) begin
            m_cnt[i] = 0; m_valid[i] = 0;
            if (ZF) m_data[i] = '0;
         end else begin
            if (en) m_done[i] = 0;
            if (!m_has[i]) begin
               if (load) begin
                  m_has[i] = 1; m_cnt[i] = 0;
                  for (int k = 0; k < D; k++) m_words[i][k] = blk[k*W +: W];
               end
            end else if (en) begin
               if (m_cnt[i] == D) begin
                  m_has[i] = 0; m_cnt[i] = 0; m_valid[i] = 0; m_done[i] = 1;
                  if (ZF) m_data[i] = '0;
               end else if (!mr[i]) begin
                  m_data[i] = m_words[i][m_cnt[i]]; m_valid[i] = 1; m_cnt[i]++;
               end
            end
         end
      end
      if (!rst_n) chk_on = 1'b1;
   end

   function automatic logic [1:0] exp_state(input int i);
      if (!m_has[i]) return ST_EMPTY;
      return (m_cnt[i] == 0) ? ST_ARMED : ST_STREAM;
   endfunction

   // compare process and stream capture
   logic [W-1:0] got0 [$];
   logic [W-1:0] got1 [$];
   int           cap0 [$];
   int           cap1 [$];
   int           done_cnt [2] = '{0, 0};
   int           cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (chk_on) begin
         check("in_ready",  bus.in_ready, !m_has[0] && !m_has[1]);
         check("valid0",    bus.out_valid0, m_valid[0]);
         check("valid1",    bus.out_valid1, m_valid[1]);
         check("data0",     bus.out_data0, m_data[0]);
         check("data1",     bus.out_data1, m_data[1]);
         check("lane_done", bus.lane_done, {m_done[1], m_done[0]});
         check("state0",    dbg0, exp_state(0));
         check("state1",    dbg1, exp_state(1));
         if (last_rst && last_en) begin
            if (bus.out_valid0) begin got0.push_back(bus.out_data0); cap0.push_back(cyc); end
            if (bus.out_valid1) begin got1.push_back(bus.out_data1); cap1.push_back(cyc); end
            if (bus.lane_done[0]) done_cnt[0]++;
            if (bus.lane_done[1]) done_cnt[1]++;
         end
      end
   end

   // driver tasks
   logic [W-1:0] exp_q [$];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_block(input logic [W-1:0] b0, input logic [W-1:0] b1);
      for (int k = 0; k < D; k++) begin
         bus.in_data0[k*W +: W] = b0 + W'(k + 1);
         bus.in_data1[k*W +: W] = b1 + W'(k + 1);
      end
   endtask

   task automatic load_block(input logic [W-1:0] b0, input logic [W-1:0] b1);
      bit ok;
      ok = 0;
      set_block(b0, b1);
      bus.in_valid = 1'b1;
      for (int t = 0; t < 40; t++) begin
         if (bus.in_ready) begin
            ok = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("load_accept", ok, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int t = 0; t < 60; t++) begin
         if (bus.in_ready && !bus.out_valid0 && !bus.out_valid1 && bus.lane_done == 2'b00) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      check("idle_timeout", ok, 1);
   endtask

   task automatic push_seq(input logic [W-1:0] base);
      for (int k = 1; k <= D; k++) exp_q.push_back(base + W'(k));
   endtask

   task automatic compare_lane(input string name, input int lane, input int start);
      int n;
      n = ((lane == 0) ? got0.size() : got1.size()) - start;
      check({name, "_len"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         check(name, (lane == 0) ? got0[start+i] : got1[start+i], exp_q[i]);
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, s1, d0, d1, a0;
      rst_n = 1'b0; en = 1'b1; mr = 2'b00;
      bus.in_valid = 1'b0; bus.in_data0 = '0; bus.in_data1 = '0;
      tick(2);
      check("rst_ready", bus.in_ready, 1);
      check("rst_valid0", bus.out_valid0, 0);
      check("rst_done", bus.lane_done, 0);
      rst_n = 1'b1;
      tick(1);

      // basic stream, both lanes released together
      s0 = got0.size(); s1 = got1.size(); d0 = done_cnt[0]; d1 = done_cnt[1];
      load_block(16'h0000, 16'h0010);
      wait_idle();
      push_seq(16'h0000); compare_lane("basic_l0", 0, s0);
      push_seq(16'h0010); compare_lane("basic_l1", 1, s1);
      check("basic_done0", done_cnt[0] - d0, 1);
      check("basic_done1", done_cnt[1] - d1, 1);

      // skew: lane1 held two extra cycles
      s0 = got0.size(); s1 = got1.size();
      mr = 2'b10;
      load_block(16'h0020, 16'h0030);
      tick(2);
      mr = 2'b00;
      wait_idle();
      check("skew_start", (got0.size() > s0 && got1.size() > s1) ? cap1[s1] - cap0[s0] : -1, 2);
      push_seq(16'h0020); compare_lane("skew_l0", 0, s0);
      push_seq(16'h0030); compare_lane("skew_l1", 1, s1);

      // stall after word 1
      s0 = got0.size(); s1 = got1.size();
      load_block(16'h0040, 16'h0050);
      tick(2);
      en = 1'b0;
      tick(3);
      check("stall_data0", bus.out_data0, 16'h0042);
      check("stall_valid0", bus.out_valid0, 1);
      en = 1'b1;
      wait_idle();
      push_seq(16'h0040); compare_lane("stall_l0", 0, s0);
      push_seq(16'h0050); compare_lane("stall_l1", 1, s1);

      // abort lane0 while it shows word 0x0002, then restart
      s0 = got0.size(); s1 = got1.size();
      load_block(16'h0000, 16'h0010);
      tick(2);
      check("abort_pre", bus.out_data0, 16'h0002);
      mr = 2'b01;
      tick(1);
      check("abort_valid0", bus.out_valid0, 0);
      check("abort_data0", bus.out_data0, ZF ? 16'h0000 : 16'h0002);
      check("abort_valid1", bus.out_valid1, 1);
      tick(1);
      mr = 2'b00;
      wait_idle();
      exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
      push_seq(16'h0000); compare_lane("abort_l0", 0, s0);
      push_seq(16'h0010); compare_lane("abort_l1", 1, s1);

      // load gating with in_valid held high: loads land six cycles apart
      s0 = got0.size(); d0 = done_cnt[0]; d1 = done_cnt[1]; a0 = acc;
      set_block(16'h0060, 16'h0070);
      bus.in_valid = 1'b1;
      tick(13);
      bus.in_valid = 1'b0;
      wait_idle();
      check("gate_accepts", acc - a0, 3);
      check("gate_done0", done_cnt[0] - d0, 3);
      check("gate_done1", done_cnt[1] - d1, 3);
      push_seq(16'h0060); push_seq(16'h0060); push_seq(16'h0060);
      compare_lane("gate_l0", 0, s0);
      check("idle_data0", bus.out_data0, ZF ? 16'h0000 : 16'h0064);

      // reset mid-stream discards the block
      load_block(16'h0000, 16'h0010);
      tick(2);
      rst_n = 1'b0;
      tick(1);
      check("mrst_valid0", bus.out_valid0, 0);
      check("mrst_valid1", bus.out_valid1, 0);
      check("mrst_data0", bus.out_data0, 0);
      check("mrst_data1", bus.out_data1, 0);
      check("mrst_ready", bus.in_ready, 1);
      check("mrst_done", bus.lane_done, 0);
      rst_n = 1'b1;
      d0 = done_cnt[0]; d1 = done_cnt[1];
      tick(6);
      check("mrst_nodone0", done_cnt[0] - d0, 0);
      check("mrst_nodone1", done_cnt[1] - d1, 0);
      check("mrst_ready_after", bus.in_ready, 1);

      // recovery block
      s0 = got0.size(); s1 = got1.size();
      load_block(16'h0080, 16'h0090);
      wait_idle();
      push_seq(16'h0080); compare_lane("post_l0", 0, s0);
      push_seq(16'h0090); compare_lane("post_l1", 1, s1);

      tick(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_stream_mux2_1.md
# input_stream_mux2_1

Two-lane operand streamer between the input block buffer and the Multi-MAC array. It accepts one block of DEPTH words per lane in a single ready/valid transfer and holds each lane armed until its bit of the 2-bit mux reset vector from the mux control stage is released. Each released lane then emits one word per enabled cycle, giving the MAC array the skewed operand streams it consumes.

## Interface
- WIDTH, 16, bits per operand word
- DEPTH, 4, words per lane per block (≥2)
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  global advance; low = stall, all state and outputs hold
- mux_reset  in  2  per-lane hold/restart from the mux control stage; bit i = 1 keeps lane i from streaming
- in_valid  in  1  upstream block valid
- in_ready  out  1  block accepted when in_valid && in_ready
- in_data0  in  WIDTH*DEPTH  lane 0 block; word k = bits [k*WIDTH +: WIDTH]
- in_data1  in  WIDTH*DEPTH  lane 1 block, same packing
- out_data0 / out_data1  out  WIDTH  lane stream words
- out_valid0 / out_valid1  out  1  lane word valid
- lane_done  out  2  one-cycle pulse per lane after its last word

## Operation
- Per-lane FSM: EMPTY, ARMED, STREAM. Word pointer ptr is $clog2(DEPTH+1) bits.
- Reset (rst_n=0 at edge): both lanes EMPTY, ptr=0, out_data*=0, out_valid*=0, lane_done=0. Buffered data is discarded, including mid-stream.
- in_ready = both lanes EMPTY (combinational from state). On in_valid && in_ready, both buffers load and both lanes go ARMED. Stalling with en does not block loading.
- ARMED with en=1 and mux_reset[i]=0: register word 0, out_valid=1, ptr=1, go to STREAM.
- STREAM with en=1, mux_reset[i]=0, ptr<DEPTH: register word[ptr], ptr++.
- STREAM with en=1, ptr==DEPTH: out_valid=0, lane_done[i]=1 for one cycle, go to EMPTY.
- STREAM with mux_reset[i]=1, regardless of en: abort. out_valid=0, ptr=0, go to ARMED. Buffer is kept, and the next release restarts at word 0.
- ARMED with mux_reset[i]=1: stays ARMED.
- en=0: no transitions, outputs frozen. Exceptions are the abort above and a block load.
- Lanes are independent. A new block is accepted only after both lanes are EMPTY.

## Timing
- Release-to-data latency is 1 cycle. Let edge k be the first edge with ARMED, en=1 and mux_reset[i]=0.
  - Word 0 is visible after edge k.
  - Word j is visible after edge k+j, for j < DEPTH.
  - out_valid falls and lane_done pulses after edge k+DEPTH.
- The earliest next load is at edge k+DEPTH+1 of the later lane, because in_ready is high in the cycle after the lane reaches EMPTY.
- Throughput: one block per DEPTH+2 cycles when both lanes are released together and en is held high.
- Load and release in the same cycle: the lane sees EMPTY, so it is only armed at that edge. Streaming starts at the next edge.

## Configuration
- STREAM_ZERO_FILL_EN
  - Defined: out_data forces to 0 whenever out_valid=0, i.e. on abort, on completion, and in EMPTY or ARMED. The MAC array then accumulates zeros outside the stream.
  - Undefined: out_data holds its last value when not valid. Only out_valid qualifies data.

## Structure
- Package input_stream_pkg holds:
  - lane state enum (EMPTY=2'd0, ARMED=2'd1, STREAM=2'd2)
  - default WIDTH and DEPTH constants
- Sub-module stream_lane is instantiated twice and contains:
  - the buffer
  - the FSM and pointer
  - the output registers
  - the done pulse
- The top level contains the in_ready AND and the port fan-out.

## Test plan
- Reset mid-stream: lanes streaming, rst_n=0 for one edge → all outputs 0, in_ready=1, and lane_done does not pulse.
- Basic stream: WIDTH=16, DEPTH=4, load lane0 words 0x0001..0x0004 and lane1 words 0x0011..0x0014, mux_reset=00, en=1 → both lanes emit 1,2,3,4 / 0x11..0x14 on consecutive cycles starting 1 cycle after release. lane_done=11 pulses after the 4th word, and in_ready rises the next cycle.
- Skew: mux_reset=10 for 2 cycles, then 00 → lane0 starts 2 cycles before lane1. in_ready stays low until lane1 finishes.
- Stall: en=0 for 3 cycles after word 1 → word 1 held with valid=1, word 2 follows the first enabled edge, and there are no duplicates or drops.
- Abort and restart: mux_reset[0]=1 while lane0 shows word 2 → valid0=0 next cycle. After release, lane0 restarts at 0x0001.
- Load gating: in_valid held high throughout → exactly one block is accepted per completion. With STREAM_ZERO_FILL_EN, out_data=0 whenever valid=0; without it, the last word is held.
